prf_freelist_ckpt: RTL and testbench

PRF_FREELIST_CKPT -- requirements
Module: prf_freelist_ckpt

---
 rtl/prf_freelist_ckpt_if.sv | 23 ++
 rtl/prf_freelist_ckpt.sv | 167 ++++++++++++++++
 tb/tb_prf_freelist_ckpt.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/prf_freelist_ckpt_if.sv
// Rename-side lanes of the physical register free list: allocation offers
// with their take strobes, and the retire lanes that return registers.
interface prf_freelist_ckpt_if #(
    parameter int WAYS = 4,
    parameter int IW   = 6
);
    logic [WAYS-1:0][IW-1:0] alloc_idx;
    logic [WAYS-1:0]         alloc_valid;
    logic [WAYS-1:0]         alloc_take;
    logic [WAYS-1:0]         ret_en;
    logic [WAYS-1:0][IW-1:0] ret_new;
    logic [WAYS-1:0][IW-1:0] ret_old;

    modport master (
        input  alloc_idx, alloc_valid,
        output alloc_take, ret_en, ret_new, ret_old
    );

    modport slave (
        output alloc_idx, alloc_valid,
        input  alloc_take, ret_en, ret_new, ret_old
    );
endinterface

// File: rtl/prf_freelist_ckpt.sv
// Physical register free list with speculative/committed vectors and branch
// checkpoints; offers the lowest free registers one cycle after they appear.
module prf_freelist_ckpt #(
    parameter  int WAYS  = 4,
    parameter  int PRF   = 64,
    parameter  int ARCH  = 32,
    parameter  int CKPTS = 4,
    localparam int IW    = $clog2(PRF),
    localparam int CW    = $clog2(CKPTS),
    localparam int NW    = $clog2(PRF + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    prf_freelist_ckpt_if.slave    fl,
    input  logic                  ckpt_req,
    output logic                  ckpt_ready,
    output logic [CW-1:0]         ckpt_id,
    input  logic                  ckpt_release,
    input  logic [CW-1:0]         ckpt_release_id,
    input  logic                  recover,
    input  logic [CW-1:0]         recover_id,
    input  logic [CKPTS-1:0]      recover_kill_mask,
    input  logic                  except,
    output logic [NW-1:0]         free_count,
    output logic [PRF-1:0]        free_spec_out,
    output logic [PRF-1:0]        free_arch_out
);

    localparam logic [PRF-1:0] RESET_VEC = {{(PRF-ARCH){1'b1}}, {ARCH{1'b0}}};

    logic [PRF-1:0]          free_spec;
    logic [PRF-1:0]          free_arch;
    logic [PRF-1:0]          free_spec_next;
    logic [PRF-1:0]          free_arch_next;
    logic [PRF-1:0]          spec_norm;
    logic [PRF-1:0]          ret_free;
    logic [PRF-1:0]          pick_mask;
    logic [PRF-1:0]          ckpt_vec [CKPTS];
    logic [CKPTS-1:0]        ckpt_valid;
    logic [CKPTS-1:0]        ckpt_valid_next;
    logic [WAYS-1:0]         take_fire;
    logic [WAYS-1:0][IW-1:0] pick_idx;
    logic [WAYS-1:0]         pick_valid;
    logic                    ckpt_alloc;

    assign take_fire = fl.alloc_valid & fl.alloc_take;

    // Committed list: each lane frees its old mapping after claiming its new one.
    always_comb begin
        ret_free       = '0;
        free_arch_next = free_arch;
        for (int i = 0; i < WAYS; i++) begin
            if (fl.ret_en[i]) begin
                ret_free[fl.ret_old[i]]       = 1'b1;
                free_arch_next[fl.ret_new[i]] = 1'b0;
                free_arch_next[fl.ret_old[i]] = 1'b1;
            end
        end
    end

    always_comb begin
        spec_norm = free_spec;
        for (int i = 0; i < WAYS; i++) begin
            if (take_fire[i]) begin
                spec_norm[fl.alloc_idx[i]] = 1'b0;
            end
        end
        spec_norm = spec_norm | ret_free;
    end

    always_comb begin
        if (except) begin
            free_spec_next = free_arch_next;
        end else if (recover) begin
            free_spec_next = ckpt_vec[recover_id] | ret_free;
        end else begin
            free_spec_next = spec_norm;
        end
    end

    // Successive lowest-set-bit search; each lane removes its pick before the next lane looks.
    always_comb begin
        pick_idx   = '0;
        pick_valid = '0;
        pick_mask  = free_spec_next;
        for (int i = 0; i < WAYS; i++) begin
            for (int k = PRF - 1; k >= 0; k--) begin
                if (pick_mask[k]) begin
                    pick_idx[i]   = IW'(k);
                    pick_valid[i] = 1'b1;
                end
            end
            if (pick_valid[i]) begin
                pick_mask[pick_idx[i]] = 1'b0;
            end
        end
    end

    always_comb begin
        free_count = '0;
        for (int k = 0; k < PRF; k++) begin
            free_count = free_count + NW'(free_spec[k]);
        end
    end

    always_comb begin
        ckpt_id = '0;
        for (int k = CKPTS - 1; k >= 0; k--) begin
            if (!ckpt_valid[k]) begin
                ckpt_id = CW'(k);
            end
        end
    end

    assign ckpt_ready = ~&ckpt_valid;
    assign ckpt_alloc = ckpt_req & ckpt_ready & ~recover & ~except;

    always_comb begin
        ckpt_valid_next = ckpt_valid;
        if (ckpt_release) begin
            ckpt_valid_next[ckpt_release_id] = 1'b0;
        end
        if (except) begin
            ckpt_valid_next = '0;
        end else if (recover) begin
            ckpt_valid_next = ckpt_valid_next & ~recover_kill_mask;
        end else if (ckpt_alloc) begin
            ckpt_valid_next[ckpt_id] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            free_spec      <= RESET_VEC;
            free_arch      <= RESET_VEC;
            ckpt_valid     <= '0;
            fl.alloc_idx   <= '0;
            fl.alloc_valid <= '0;
            for (int k = 0; k < CKPTS; k++) begin
                ckpt_vec[k] <= '0;
            end
        end else begin
            free_spec  <= free_spec_next;
            free_arch  <= free_arch_next;
            ckpt_valid <= ckpt_valid_next;
            // Retired frees must survive a later rollback to any live checkpoint.
            for (int k = 0; k < CKPTS; k++) begin
                if (ckpt_alloc && (ckpt_id == CW'(k))) begin
                    ckpt_vec[k] <= free_spec_next;
                end else if (ckpt_valid[k]) begin
                    ckpt_vec[k] <= ckpt_vec[k] | ret_free;
                end
            end
            if (except || recover) begin
                fl.alloc_idx   <= '0;
                fl.alloc_valid <= '0;
            end else begin
                fl.alloc_idx   <= pick_idx;
                fl.alloc_valid <= pick_valid;
            end
        end
    end

    assign free_spec_out = free_spec;
    assign free_arch_out = free_arch;

endmodule

// File: tb/tb_prf_freelist_ckpt.sv
// Directed bench for prf_freelist_ckpt: hand-computed offers, counts and
// free vectors across allocation, retire, checkpoint, recovery and flush.
module tb_prf_freelist_ckpt;
    localparam int WAYS  = 4;
    localparam int PRF   = 64;
    localparam int ARCH  = 32;
    localparam int CKPTS = 4;
    localparam int IW    = $clog2(PRF);
    localparam int CW    = $clog2(CKPTS);
    localparam int NW    = $clog2(PRF + 1);

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    prf_freelist_ckpt_if #(.WAYS(WAYS), .IW(IW)) fl_if ();

    logic              ckpt_req;
    logic              ckpt_ready;
    logic [CW-1:0]     ckpt_id;
    logic              ckpt_release;
    logic [CW-1:0]     ckpt_release_id;
    logic              recover;
    logic [CW-1:0]     recover_id;
    logic [CKPTS-1:0]  recover_kill_mask;
    logic              except;
    logic [NW-1:0]     free_count;
    logic [PRF-1:0]    free_spec_out;
    logic [PRF-1:0]    free_arch_out;

    prf_freelist_ckpt #(.WAYS(WAYS), .PRF(PRF), .ARCH(ARCH), .CKPTS(CKPTS)) dut (
        .clock             (clock),
        .reset             (reset),
        .fl                (fl_if.slave),
        .ckpt_req          (ckpt_req),
        .ckpt_ready        (ckpt_ready),
        .ckpt_id           (ckpt_id),
        .ckpt_release      (ckpt_release),
        .ckpt_release_id   (ckpt_release_id),
        .recover           (recover),
        .recover_id        (recover_id),
        .recover_kill_mask (recover_kill_mask),
        .except            (except),
        .free_count        (free_count),
        .free_spec_out     (free_spec_out),
        .free_arch_out     (free_arch_out)
    );

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [63:0] RESET_VEC = {32'hFFFF_FFFF, 32'h0000_0000};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WAYS*IW-1:0] ofs(input int l3, input int l2, input int l1, input int l0);
        return {IW'(l3), IW'(l2), IW'(l1), IW'(l0)};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        fl_if.alloc_take  = '0;
        fl_if.ret_en      = '0;
        fl_if.ret_new     = '0;
        fl_if.ret_old     = '0;
        ckpt_req          = 1'b0;
        ckpt_release      = 1'b0;
        ckpt_release_id   = '0;
        recover           = 1'b0;
        recover_id        = '0;
        recover_kill_mask = '0;
        except            = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        chk("rst_valid", 64'(fl_if.alloc_valid), 64'h0);
        chk("rst_idx", 64'(fl_if.alloc_idx), 64'h0);
        chk("rst_count", 64'(free_count), 64'd32);
        chk("rst_spec", free_spec_out, RESET_VEC);
        chk("rst_arch", free_arch_out, RESET_VEC);
        chk("rst_ready", 64'(ckpt_ready), 64'd1);
        chk("rst_ckid", 64'(ckpt_id), 64'd0);

        reset = 1'b0;
        #1;
        chk("post_rst_bubble", 64'(fl_if.alloc_valid), 64'h0);
        tick();
        chk("idle_valid", 64'(fl_if.alloc_valid), 64'hF);
        chk("idle_idx", 64'(fl_if.alloc_idx), 64'(ofs(35, 34, 33, 32)));
        chk("idle_count", 64'(free_count), 64'd32);

        // Drain the whole free list four at a time.
        fl_if.alloc_take = 4'b1111;
        for (int c = 0; c < 7; c++) begin
            tick();
            chk("drain_idx", 64'(fl_if.alloc_idx), 64'(ofs(39 + 4*c, 38 + 4*c, 37 + 4*c, 36 + 4*c)));
            chk("drain_count", 64'(free_count), 64'(28 - 4*c));
        end
        tick();
        chk("empty_valid", 64'(fl_if.alloc_valid), 64'h0);
        chk("empty_idx", 64'(fl_if.alloc_idx), 64'h0);
        chk("empty_count", 64'(free_count), 64'd0);
        tick();
        chk("empty_take_count", 64'(free_count), 64'd0);
        chk("empty_take_spec", free_spec_out, 64'h0);
        fl_if.alloc_take = '0;
        fl_if.ret_en     = 4'b0001;
        fl_if.ret_old    = ofs(0, 0, 0, 5);
        fl_if.ret_new    = ofs(0, 0, 0, 32);
        tick();
        idle();
        chk("ret5_idx", 64'(fl_if.alloc_idx), 64'(ofs(0, 0, 0, 5)));
        chk("ret5_valid", 64'(fl_if.alloc_valid), 64'h1);
        chk("ret5_count", 64'(free_count), 64'd1);
        chk("ret5_arch", free_arch_out, {32'hFFFF_FFFE, 32'h0000_0020});

        // Checkpoint while taking two, take four more, then roll back.
        do_reset();
        chk("ck_id0", 64'(ckpt_id), 64'd0);
        ckpt_req         = 1'b1;
        fl_if.alloc_take = 4'b0011;
        tick();
        chk("ck_after_idx", 64'(fl_if.alloc_idx), 64'(ofs(37, 36, 35, 34)));
        chk("ck_after_id", 64'(ckpt_id), 64'd1);
        ckpt_req         = 1'b0;
        fl_if.alloc_take = 4'b1111;
        tick();
        chk("ck_take4_count", 64'(free_count), 64'd26);
        fl_if.alloc_take  = '0;
        recover           = 1'b1;
        recover_id        = 2'd0;
        recover_kill_mask = 4'b0001;
        tick();
        idle();
        chk("rec_count", 64'(free_count), 64'd30);
        chk("rec_bubble", 64'(fl_if.alloc_valid), 64'h0);
        chk("rec_ckid", 64'(ckpt_id), 64'd0);
        tick();
        chk("rec_idx", 64'(fl_if.alloc_idx), 64'(ofs(37, 36, 35, 34)));
        chk("rec_valid", 64'(fl_if.alloc_valid), 64'hF);

        // A retire after the checkpoint must survive the rollback.
        do_reset();
        ckpt_req = 1'b1;
        tick();
        ckpt_req      = 1'b0;
        fl_if.ret_en  = 4'b0001;
        fl_if.ret_old = ofs(0, 0, 0, 3);
        fl_if.ret_new = ofs(0, 0, 0, 40);
        tick();
        chk("r3_idx", 64'(fl_if.alloc_idx), 64'(ofs(34, 33, 32, 3)));
        fl_if.ret_en     = '0;
        fl_if.alloc_take = 4'b1111;
        tick();
        chk("r3_take_count", 64'(free_count), 64'd29);
        fl_if.alloc_take  = '0;
        recover           = 1'b1;
        recover_id        = 2'd0;
        recover_kill_mask = 4'b0001;
        tick();
        idle();
        chk("r3_spec", free_spec_out, {32'hFFFF_FFFF, 32'h0000_0008});
        chk("r3_count", 64'(free_count), 64'd33);

        // Fill every slot, then release and combined release+recover.
        do_reset();
        ckpt_req = 1'b1;
        chk("fill_id0", 64'(ckpt_id), 64'd0);
        tick();
        chk("fill_id1", 64'(ckpt_id), 64'd1);
        tick();
        chk("fill_id2", 64'(ckpt_id), 64'd2);
        tick();
        chk("fill_id3", 64'(ckpt_id), 64'd3);
        tick();
        chk("full_ready", 64'(ckpt_ready), 64'd0);
        tick();
        chk("fifth_ignored", 64'(ckpt_ready), 64'd0);
        ckpt_req        = 1'b0;
        ckpt_release    = 1'b1;
        ckpt_release_id = 2'd2;
        tick();
        chk("rel2_id", 64'(ckpt_id), 64'd2);
        chk("rel2_ready", 64'(ckpt_ready), 64'd1);
        ckpt_release_id   = 2'd1;
        recover           = 1'b1;
        recover_id        = 2'd3;
        recover_kill_mask = 4'b1000;
        tick();
        idle();
        chk("relrec_id", 64'(ckpt_id), 64'd1);
        chk("relrec_count", 64'(free_count), 64'd32);
        chk("relrec_valid", 64'(fl_if.alloc_valid), 64'h0);

        // Exception wins over a concurrent recover and takes.
        do_reset();
        fl_if.alloc_take = 4'b0011;
        tick();
        fl_if.alloc_take = '0;
        ckpt_req         = 1'b1;
        tick();
        chk("ex_pre_id", 64'(ckpt_id), 64'd1);
        ckpt_req          = 1'b0;
        except            = 1'b1;
        recover           = 1'b1;
        recover_id        = 2'd0;
        recover_kill_mask = 4'b0001;
        fl_if.alloc_take  = 4'b1111;
        fl_if.ret_en      = 4'b0001;
        fl_if.ret_old     = ofs(0, 0, 0, 7);
        fl_if.ret_new     = ofs(0, 0, 0, 32);
        tick();
        idle();
        chk("ex_spec", free_spec_out, {32'hFFFF_FFFE, 32'h0000_0080});
        chk("ex_arch", free_arch_out, {32'hFFFF_FFFE, 32'h0000_0080});
        chk("ex_count", 64'(free_count), 64'd32);
        chk("ex_valid", 64'(fl_if.alloc_valid), 64'h0);
        chk("ex_ckid", 64'(ckpt_id), 64'd0);
        chk("ex_ready", 64'(ckpt_ready), 64'd1);
        tick();
        chk("ex_next_idx", 64'(fl_if.alloc_idx), 64'(ofs(35, 34, 33, 7)));
        chk("ex_next_valid", 64'(fl_if.alloc_valid), 64'hF);

        // Reset overrides activity in the same cycle.
        reset            = 1'b1;
        fl_if.alloc_take = 4'b1111;
        ckpt_req         = 1'b1;
        fl_if.ret_en     = 4'b0001;
        fl_if.ret_old    = ofs(0, 0, 0, 2);
        tick();
        chk("midrst_valid", 64'(fl_if.alloc_valid), 64'h0);
        chk("midrst_spec", free_spec_out, RESET_VEC);
        chk("midrst_arch", free_arch_out, RESET_VEC);
        chk("midrst_ckid", 64'(ckpt_id), 64'd0);
        idle();
        reset = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
